// File: rtl/bcd_to_score.sv
// bcd_to_score: four-digit BCD to 15-bit binary converter.
// One Horner step (acc*10 + digit) per clock, start/busy/done handshake.
// Digits are captured when a request is accepted, so the inputs may change
// freely while a conversion runs.
module bcd_to_score (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  thousands,
  input  logic [3:0]  hundreds,
  input  logic [3:0]  tens,
  input  logic [3:0]  ones,
  output logic [14:0] score,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StD3, StD2, StD1, StD0} state_e;

  state_e      state_q, state_d;
  logic [3:0]  d3_q, d3_d;
  logic [3:0]  d2_q, d2_d;
  logic [3:0]  d1_q, d1_d;
  logic [3:0]  d0_q, d0_d;
  logic [13:0] acc_q, acc_d;
  logic [13:0] score_q, score_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        invalid;
  logic [3:0]  digit_sel;
  logic [13:0] acc_x10;
  logic [13:0] horner;

  // A request is rejected if any incoming digit is outside 0..9.
  assign invalid = (thousands > 4'd9) || (hundreds > 4'd9) ||
                   (tens > 4'd9) || (ones > 4'd9);

  // acc never exceeds 999 before the final step, so 14 bits cannot overflow.
  assign acc_x10 = (acc_q << 3) + (acc_q << 1);
  assign horner  = acc_x10 + {10'd0, digit_sel};

  // Select the captured digit consumed by the current Horner step.
  always_comb begin
    digit_sel = 4'd0;
    unique case (state_q)
      StD3:    digit_sel = d3_q;
      StD2:    digit_sel = d2_q;
      StD1:    digit_sel = d1_q;
      StD0:    digit_sel = d0_q;
      default: digit_sel = 4'd0;
    endcase
  end

  // Next-state logic: accept/reject in idle, then one digit per cycle.
  always_comb begin
    state_d = state_q;
    d3_d    = d3_q;
    d2_d    = d2_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    acc_d   = acc_q;
    score_d = score_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          d3_d  = thousands;
          d2_d  = hundreds;
          d1_d  = tens;
          d0_d  = ones;
          err_d = 1'b0;
          if (invalid) begin
            // Rejected: pulse done with err, keep the previous score.
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            acc_d   = 14'd0;
            state_d = StD3;
          end
        end
      end
      StD3: begin
        acc_d   = {10'd0, d3_q};
        state_d = StD2;
      end
      StD2: begin
        acc_d   = horner;
        state_d = StD1;
      end
      StD1: begin
        acc_d   = horner;
        state_d = StD0;
      end
      StD0: begin
        score_d = horner;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      d3_q    <= 4'd0;
      d2_q    <= 4'd0;
      d1_q    <= 4'd0;
      d0_q    <= 4'd0;
      acc_q   <= 14'd0;
      score_q <= 14'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d3_q    <= d3_d;
      d2_q    <= d2_d;
      d1_q    <= d1_d;
      d0_q    <= d0_d;
      acc_q   <= acc_d;
      score_q <= score_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign score = {1'b0, score_q};
  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_to_score.sv
// Testbench for bcd_to_score: table-driven vectors plus hand-written
// sequences, with a scoreboard queue checked on every done pulse.
module tb_bcd_to_score;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  thousands, hundreds, tens, ones;
  logic [14:0] score;
  logic        busy, done, err;

  typedef struct {
    logic [3:0]  th, hu, te, on;
    logic [14:0] exp_score;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [14:0] score;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  bcd_to_score dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .thousands(thousands),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .score    (score),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_digits(input logic [3:0] a, b, c, d);
    thousands = a; hundreds = b; tens = c; ones = d;
  endtask

  task automatic churn();
    set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_score", int'(score), int'(e.score));
        chk("sb_err", int'(err), int'(e.err));
        chk("score_msb", int'(score[14]), 0);
      end
    end
  end

  // One request from idle, with handshake timing checked cycle by cycle.
  task automatic run_vec(input vec_t v);
    exp_t e;
    e.score = v.exp_score;
    e.err   = v.exp_err;
    sb_q.push_back(e);
    set_digits(v.th, v.hu, v.te, v.on);
    start = 1'b1;
    tick();  // edge k
    start = 1'b0;
    if (v.exp_err) begin
      chk("inv_done", int'(done), 1);
      chk("inv_err", int'(err), 1);
      chk("inv_busy", int'(busy), 0);
      chk("inv_score_kept", int'(score), int'(v.exp_score));
      tick();
      chk("inv_done_fall", int'(done), 0);
      chk("inv_err_sticky", int'(err), 1);
      chk("inv_busy_later", int'(busy), 0);
    end else begin
      chk("acc_busy", int'(busy), 1);
      chk("acc_err_clr", int'(err), 0);
      churn();
      for (int i = 1; i <= 3; i++) begin
        tick();
        chk("run_busy", int'(busy), 1);
        chk("run_done", int'(done), 0);
        churn();
      end
      tick();  // edge k+4
      chk("fin_done", int'(done), 1);
      chk("fin_busy", int'(busy), 0);
      chk("fin_score", int'(score), int'(v.exp_score));
      tick();
      chk("post_done", int'(done), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'd0, 4'd0, 4'd0, 4'd0, 15'd0,    1'b0};
    vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 15'd9999, 1'b0};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd7, 15'd7,    1'b0};
    vecs[3] = '{4'd1, 4'd2, 4'd3, 4'd4, 15'd1234, 1'b0};
    vecs[4] = '{4'd0, 4'hA, 4'd0, 4'd0, 15'd1234, 1'b1};
    vecs[5] = '{4'd5, 4'd0, 4'd6, 4'd0, 15'd5060, 1'b0};
    vecs[6] = '{4'hF, 4'd9, 4'd9, 4'd9, 15'd5060, 1'b1};
    vecs[7] = '{4'd1, 4'd0, 4'd0, 4'd0, 15'd1000, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    #12;
    chk("rst_score", int'(score), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    tick();
    rst_n = 1'b1;

    // Table vectors, back to back from idle.
    foreach (vecs[i]) run_vec(vecs[i]);

    // Start pulses and digit churn during busy: exactly one result.
    begin
      exp_t e;
      e.score = 15'd3141; e.err = 1'b0;
      sb_q.push_back(e);
      set_digits(4'd3, 4'd1, 4'd4, 4'd1);
      start = 1'b1;
      tick();  // edge k
      for (int i = 1; i <= 3; i++) begin
        start = (i != 2);
        churn();
        tick();
      end
      start = 1'b0;  // after edge k+3
      tick();        // edge k+4
      chk("churn_done", int'(done), 1);
      chk("churn_score", int'(score), 3141);
      tick();
      chk("churn_no_restart", int'(busy), 0);
      chk("churn_done_fall", int'(done), 0);
      repeat (3) tick();
    end

    // Back-to-back: start held high across two conversions.
    begin
      exp_t e;
      e.score = 15'd42;   e.err = 1'b0; sb_q.push_back(e);
      e.score = 15'd8765; e.err = 1'b0; sb_q.push_back(e);
      set_digits(4'd0, 4'd0, 4'd4, 4'd2);
      start = 1'b1;
      tick();  // edge k
      set_digits(4'd8, 4'd7, 4'd6, 4'd5);
      repeat (4) tick();  // edge k+4
      chk("b2b_done1", int'(done), 1);
      chk("b2b_score1", int'(score), 42);
      chk("b2b_busy1", int'(busy), 0);
      tick();  // edge k+5
      start = 1'b0;
      chk("b2b_reaccept_busy", int'(busy), 1);
      chk("b2b_reaccept_done", int'(done), 0);
      repeat (4) tick();  // edge k+9
      chk("b2b_done2", int'(done), 1);
      chk("b2b_score2", int'(score), 8765);
      tick();
      chk("b2b_idle", int'(busy), 0);
    end

    // Reset mid-conversion aborts without a done pulse.
    set_digits(4'd9, 4'd8, 4'd7, 4'd6);
    start = 1'b1;
    tick();  // edge k
    start = 1'b0;
    tick();
    tick();  // edge k+2
    rst_n = 1'b0;
    #1;
    chk("abort_score", int'(score), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_err", int'(err), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("abort_still_idle", int'(busy), 0);
    chk("abort_score_held", int'(score), 0);
    begin
      vec_t v;
      v = '{4'd2, 4'd0, 4'd2, 4'd4, 15'd2024, 1'b0};
      run_vec(v);
    end

    repeat (2) tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
